// File: rtl/apb_mem_slave.sv
// APB4 memory-backed slave with byte strobes, wait states and PSLVERR.
// Wait states come from a fixed count or from a 16-bit Fibonacci LFSR.
module apb_mem_slave #(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          DATA_WIDTH  = 16,
  parameter int          DEPTH       = 128,
  parameter int          WAIT_MODE   = 0,
  parameter int          WAIT_CYCLES = 0,
  parameter int          MAX_WAIT    = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int BYTE_LSB = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int IDX_W    = ADDR_WIDTH - BYTE_LSB;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [AW-1:0]    widx;
  logic             in_range;
  logic             setup;
  logic             commit;
  logic             start;
  logic             done;
  logic             lfsr_fb;
  logic [3:0]       wait_n;

  assign idx      = PADDR[ADDR_WIDTH-1:BYTE_LSB];
  assign widx     = idx[AW-1:0];
  assign in_range = (32'(idx) < 32'(DEPTH));
  assign setup    = PSEL & ~PENABLE;
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  assign wait_n = (WAIT_MODE == 0) ? 4'(WAIT_CYCLES)
                : 4'({1'b0, lfsr_q[3:0]} % 5'(MAX_WAIT + 1));

  assign PREADY  = (state_q == RESP);
  assign PSLVERR = slverr_q;
  assign PRDATA  = rdata_q;
  assign commit  = PREADY & PSEL & PENABLE & PWRITE & in_range;

  if (BYTE_LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^PADDR[BYTE_LSB-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    rdata_d  = rdata_q;
    slverr_d = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: start = setup;
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        start   = setup;
      end
      default: state_d = IDLE;
    endcase
    // N is sampled from the pre-advance LFSR value
    if (start) begin
      lfsr_d  = {lfsr_q[14:0], lfsr_fb};
      cnt_d   = wait_n;
      state_d = ACCESS;
      if (wait_n == 4'd0) done = 1'b1;
    end
    if (done) begin
      state_d  = RESP;
      cnt_d    = 4'd0;
      slverr_d = ~in_range;
      if (!PWRITE) rdata_d = in_range ? mem_q[widx] : '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
    end
  end

  // Storage survives reset; commit is gated by the reset-cleared state
  always_ff @(posedge PCLK) begin
    if (commit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (PSTRB[i]) mem_q[widx][8*i +: 8] <= PWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: zero-wait, fixed-wait and LFSR-wait instances.
// Expectations come from directed constants and an array/LFSR reference model.
module tb_apb_mem_slave;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [15:0] pwdata;
  logic [1:0]  pstrb;
  logic [15:0] prdata0, prdata1, prdata2;
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int checks = 0;
  int errors = 0;
  int seq1 [200];

  always #5 clk = ~clk;

  apb_mem_slave #(.WAIT_MODE(0), .WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata0), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_mem_slave #(.WAIT_MODE(0), .WAIT_CYCLES(3)) u_w3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata1), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  apb_mem_slave #(.WAIT_MODE(1), .MAX_WAIT(3), .LFSR_SEED(16'hACE1)) u_rnd (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata2), .PREADY(pready[2]), .PSLVERR(pslverr[2])
  );

  function automatic logic [15:0] prd(input int d);
    case (d)
      0:       return prdata0;
      1:       return prdata1;
      default: return prdata2;
    endcase
  endfunction

  // One APB transfer; starts just after a rising edge, w = observed wait states
  task automatic xfer(input int d, input logic wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic [1:0] st,
                      output logic [15:0] rd, output logic er, output int w);
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;
    @(posedge clk);
    #1 penable = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (pready[d]) break;
      w++;
      if (w > 40) break;
    end
    rd = prd(d);
    er = pslverr[d];
    @(posedge clk);
    #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    psel = 3'b000; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pready !== 3'b000) begin
      errors++;
      $display("FAIL reset_pready: got %b want 000", pready);
    end
    checks++;
    if (pslverr !== 3'b000) begin
      errors++;
      $display("FAIL reset_pslverr: got %b want 000", pslverr);
    end
    checks++;
    if ({prdata0, prdata1, prdata2} !== 48'h0) begin
      errors++;
      $display("FAIL reset_prdata: got %h %h %h want 0", prdata0, prdata1, prdata2);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_wait();
    logic [15:0] rd;
    logic er;
    int w;
    xfer(0, 1, 16'h0004, 16'hBEEF, 2'b11, rd, er, w);
    checks++;
    if (w !== 0 || er !== 1'b0) begin
      errors++;
      $display("FAIL zw_write: waits=%0d err=%b want waits=0 err=0", w, er);
    end
    xfer(0, 0, 16'h0004, 16'h0000, 2'b11, rd, er, w);
    checks++;
    if (w !== 0 || er !== 1'b0 || rd !== 16'hBEEF) begin
      errors++;
      $display("FAIL zw_read: waits=%0d err=%b data=%h want 0 0 beef", w, er, rd);
    end
    xfer(0, 0, 16'h0005, 16'h0000, 2'b00, rd, er, w);
    checks++;
    if (rd !== 16'hBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL zw_lsb_ignored: data=%h err=%b want beef 0", rd, er);
    end
  endtask

  task automatic test_strobe();
    logic [15:0] rd;
    logic er;
    int w;
    xfer(0, 1, 16'h0010, 16'h1234, 2'b11, rd, er, w);
    xfer(0, 1, 16'h0010, 16'hABCD, 2'b10, rd, er, w);
    xfer(0, 0, 16'h0010, 16'h0000, 2'b00, rd, er, w);
    checks++;
    if (rd !== 16'hAB34) begin
      errors++;
      $display("FAIL strb_hi: data=%h want ab34", rd);
    end
    xfer(0, 1, 16'h0010, 16'hFFFF, 2'b00, rd, er, w);
    checks++;
    if (er !== 1'b0) begin
      errors++;
      $display("FAIL strb_none_err: err=%b want 0", er);
    end
    xfer(0, 0, 16'h0010, 16'h0000, 2'b11, rd, er, w);
    checks++;
    if (rd !== 16'hAB34) begin
      errors++;
      $display("FAIL strb_none: data=%h want ab34", rd);
    end
    xfer(0, 1, 16'h0010, 16'h99EE, 2'b01, rd, er, w);
    xfer(0, 0, 16'h0010, 16'h0000, 2'b10, rd, er, w);
    checks++;
    if (rd !== 16'hABEE) begin
      errors++;
      $display("FAIL strb_lo: data=%h want abee", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd;
    logic er;
    int w;
    xfer(0, 1, 16'h00FE, 16'h5A5A, 2'b11, rd, er, w);
    xfer(0, 1, 16'h0100, 16'hFFFF, 2'b11, rd, er, w);
    checks++;
    if (er !== 1'b1 || w !== 0) begin
      errors++;
      $display("FAIL oor_write: err=%b waits=%0d want 1 0", er, w);
    end
    checks++;
    if (pslverr[0] !== 1'b0) begin
      errors++;
      $display("FAIL oor_err_clear: pslverr=%b want 0", pslverr[0]);
    end
    xfer(0, 0, 16'h0100, 16'h0000, 2'b11, rd, er, w);
    checks++;
    if (er !== 1'b1 || rd !== 16'h0000) begin
      errors++;
      $display("FAIL oor_read: err=%b data=%h want 1 0000", er, rd);
    end
    xfer(0, 0, 16'h00FE, 16'h0000, 2'b11, rd, er, w);
    checks++;
    if (er !== 1'b0 || rd !== 16'h5A5A) begin
      errors++;
      $display("FAIL oor_word127: err=%b data=%h want 0 5a5a", er, rd);
    end
    xfer(0, 0, 16'hFFFE, 16'h0000, 2'b11, rd, er, w);
    checks++;
    if (er !== 1'b1 || rd !== 16'h0000) begin
      errors++;
      $display("FAIL oor_top: err=%b data=%h want 1 0000", er, rd);
    end
  endtask

  task automatic test_fixed_wait();
    logic [15:0] rd;
    logic er;
    int w;
    int seen;
    time t0;
    t0 = $time;
    xfer(1, 1, 16'h0020, 16'h1111, 2'b11, rd, er, w);
    checks++;
    if (w !== 3 || er !== 1'b0) begin
      errors++;
      $display("FAIL fw_write: waits=%0d err=%b want 3 0", w, er);
    end
    xfer(1, 0, 16'h0020, 16'h0000, 2'b11, rd, er, w);
    checks++;
    if (($time - t0) !== 100) begin
      errors++;
      $display("FAIL fw_throughput: two transfers took %0t want 100", $time - t0);
    end
    psel = 3'b010; penable = 0; pwrite = 1;
    paddr = 16'h0020; pwdata = 16'h2222; pstrb = 2'b11;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1;
    psel = 3'b000;
    penable = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (pready[1]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL fw_abort_ready: pready cycles=%0d want 0", seen);
    end
    @(posedge clk);
    #1;
    xfer(1, 0, 16'h0020, 16'h0000, 2'b11, rd, er, w);
    checks++;
    if (rd !== 16'h1111 || w !== 3 || er !== 1'b0) begin
      errors++;
      $display("FAIL fw_abort_nowrite: data=%h waits=%0d err=%b want 1111 3 0", rd, w, er);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    logic er;
    int w;
    xfer(1, 1, 16'h0030, 16'h7777, 2'b11, rd, er, w);
    psel = 3'b010; penable = 0; pwrite = 1;
    paddr = 16'h0030; pwdata = 16'h8888; pstrb = 2'b11;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pready[1] !== 1'b0) begin
      errors++;
      $display("FAIL rm_ready: pready=%b want 0", pready[1]);
    end
    @(negedge clk);
    psel = 3'b000;
    penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    xfer(1, 0, 16'h0030, 16'h0000, 2'b11, rd, er, w);
    checks++;
    if (rd !== 16'h7777 || w !== 3 || er !== 1'b0) begin
      errors++;
      $display("FAIL rm_read: data=%h waits=%0d err=%b want 7777 3 0", rd, w, er);
    end
    // Reset during the response cycle must clear outputs asynchronously
    psel = 3'b001; penable = 0; pwrite = 0;
    paddr = 16'h0004; pstrb = 2'b00;
    @(posedge clk);
    #1 penable = 1'b1;
    checks++;
    if (pready[0] !== 1'b1 || prdata0 !== 16'hBEEF) begin
      errors++;
      $display("FAIL rm_resp: pready=%b data=%h want 1 beef", pready[0], prdata0);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pready[0] !== 1'b0 || prdata0 !== 16'h0000 || pslverr[0] !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: pready=%b data=%h err=%b want 0 0000 0",
               pready[0], prdata0, pslverr[0]);
    end
    @(negedge clk);
    psel = 3'b000;
    penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_wait();
    logic [15:0] mdl [128];
    logic [1:0]  vld [128];
    logic [15:0] lf;
    int          hist [4];
    logic [15:0] rd, wd, a;
    logic        er, wr, oor;
    logic [1:0]  st;
    int          w, word, exp_n;
    lf = 16'hACE1;
    for (int i = 0; i < 128; i++) vld[i] = 2'b00;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    for (int i = 0; i < 200; i++) begin
      wr   = (i < 30) ? 1'b1 : 1'($urandom_range(0, 1));
      word = $urandom_range(0, 135);
      a    = 16'(word * 2 + $urandom_range(0, 1));
      wd   = 16'($urandom);
      st   = 2'($urandom_range(0, 3));
      oor  = (word >= 128);
      exp_n = int'(lf[3:0]) % 4;
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
      xfer(2, wr, a, wd, st, rd, er, w);
      seq1[i] = w;
      if (w >= 0 && w <= 3) hist[w]++;
      checks++;
      if (w !== exp_n) begin
        errors++;
        $display("FAIL rnd_wait[%0d]: waits=%0d want %0d", i, w, exp_n);
      end
      checks++;
      if (er !== oor) begin
        errors++;
        $display("FAIL rnd_err[%0d]: err=%b want %b", i, er, oor);
      end
      if (!wr && oor) begin
        checks++;
        if (rd !== 16'h0000) begin
          errors++;
          $display("FAIL rnd_oor_data[%0d]: data=%h want 0000", i, rd);
        end
      end else if (!wr && vld[word] == 2'b11) begin
        checks++;
        if (rd !== mdl[word]) begin
          errors++;
          $display("FAIL rnd_data[%0d]: data=%h want %h", i, rd, mdl[word]);
        end
      end
      if (wr && !oor) begin
        if (st[0]) mdl[word][7:0]  = wd[7:0];
        if (st[1]) mdl[word][15:8] = wd[15:8];
        vld[word] = vld[word] | st;
      end
    end
    for (int v = 0; v < 4; v++) begin
      checks++;
      if (hist[v] == 0) begin
        errors++;
        $display("FAIL rnd_cover: wait %0d seen %0d times want >0", v, hist[v]);
      end
    end
  endtask

  task automatic test_repeat_seed();
    logic [15:0] rd;
    logic er;
    int w;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 200; i++) begin
      xfer(2, 0, 16'h0000, 16'h0000, 2'b00, rd, er, w);
      checks++;
      if (w !== seq1[i]) begin
        errors++;
        $display("FAIL seed_repeat[%0d]: waits=%0d want %0d", i, w, seq1[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_strobe();
    test_out_of_range();
    test_fixed_wait();
    test_reset_mid();
    test_random_wait();
    test_repeat_seed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
